// File: rtl/stack_pkg.sv
// stack_pkg: opcodes, FSM state encoding and default widths shared by the
// scratch-stack controller and its users.
package stack_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 8;
   typedef enum logic [1:0] {
      OP_PUSH    = 2'b00,
      OP_POP     = 2'b01,
      OP_REPLACE = 2'b10,
      OP_SWAP    = 2'b11
   } op_e;
   typedef enum logic [2:0] {
      S_IDLE,
      S_WR,
      S_RD_WAIT,
      S_RD_CAP,
      S_SW_WR
   } state_e;
endpackage

// File: rtl/stack_ctrl_if.sv
// stack_ctrl_if: command/response, status and scratch-RAM signals of stack_ctrl.
interface stack_ctrl_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 8
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [DATA_W-1:0] cmd_data;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_data;
   logic [DATA_W-1:0] tos;
   logic [ADDR_W:0]   count;
   logic              err_ovf;
   logic              err_unf;
   logic              err_clr;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic              ram_wen;
   logic [DATA_W-1:0] ram_rdata;
   modport master (
      output cmd_valid, cmd_op, cmd_data, err_clr, ram_rdata,
      input  cmd_ready, rsp_valid, rsp_data, tos, count, err_ovf, err_unf,
             ram_addr, ram_wdata, ram_wen
   );
   modport slave (
      input  cmd_valid, cmd_op, cmd_data, err_clr, ram_rdata,
      output cmd_ready, rsp_valid, rsp_data, tos, count, err_ovf, err_unf,
             ram_addr, ram_wdata, ram_wen
   );
endinterface

// File: rtl/stack_ctrl.sv
// stack_ctrl: scratch-stack sequencer; TOS lives in a register, deeper cells
// spill to an external 1-cycle-read RAM.
module stack_ctrl
   import stack_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input logic         CLK,
   input logic         resetn,
   stack_ctrl_if.slave bus
);
   localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'((1 << ADDR_W) + 1);
   state_e            state_q;
   logic              swap_q, wen_q, rsp_valid_q, err_ovf_q, err_unf_q;
   logic [DATA_W-1:0] tos_q, wdata_q, rsp_data_q;
   logic [ADDR_W:0]   count_q;
   logic [ADDR_W-1:0] addr_q, sp, sp_m1;
   logic              accept, empty, full, deep, ovf_set, unf_set;
   op_e               op;
   assign op      = op_e'(bus.cmd_op);
   assign accept  = bus.cmd_valid && state_q == S_IDLE;
   assign empty   = count_q == '0;
   assign full    = count_q == FULL;
   assign deep    = count_q > ONE;
   assign sp      = ADDR_W'(count_q - ONE);
   assign sp_m1   = ADDR_W'(count_q - 2 * ONE);
   assign ovf_set = accept && op == OP_PUSH && full;
   assign unf_set = accept && ((op == OP_POP && empty) || (op == OP_SWAP && !deep));
   always_ff @(posedge CLK or negedge resetn)
      if (!resetn) begin
         state_q     <= S_IDLE;
         swap_q      <= 1'b0;
         tos_q       <= '0;
         count_q     <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wen_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         err_ovf_q   <= 1'b0;
         err_unf_q   <= 1'b0;
      end else begin
         wen_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         err_ovf_q   <= !bus.err_clr && (err_ovf_q || ovf_set);
         err_unf_q   <= !bus.err_clr && (err_unf_q || unf_set);
         case (state_q)
            S_IDLE: if (accept) begin
               swap_q <= op == OP_SWAP;
               case (op)
                  OP_PUSH: if (empty) begin
                     tos_q   <= bus.cmd_data;
                     count_q <= ONE;
                  end else if (!full) begin
                     addr_q  <= sp;
                     wdata_q <= tos_q;
                     wen_q   <= 1'b1;
                     tos_q   <= bus.cmd_data;
                     count_q <= count_q + ONE;
                     state_q <= S_WR;
                  end
                  OP_POP: begin
                     // tos is held at 0 while empty, so this also yields 0 on underflow
                     rsp_valid_q <= 1'b1;
                     rsp_data_q  <= tos_q;
                     if (count_q == ONE) begin
                        tos_q   <= '0;
                        count_q <= '0;
                     end else if (deep) begin
                        addr_q  <= sp_m1;
                        count_q <= count_q - ONE;
                        state_q <= S_RD_WAIT;
                     end
                  end
                  OP_REPLACE: begin
                     tos_q <= bus.cmd_data;
                     if (empty) count_q <= ONE;
                  end
                  OP_SWAP: begin
                     rsp_valid_q <= 1'b1;
                     rsp_data_q  <= tos_q;
                     if (deep) begin
                        addr_q  <= sp_m1;
                        wdata_q <= tos_q;
                        state_q <= S_RD_WAIT;
                     end
                  end
               endcase
            end
            S_WR:      state_q <= S_IDLE;
            S_RD_WAIT: state_q <= S_RD_CAP;
            S_RD_CAP: begin
               // SWAP writes the old TOS (staged in wdata_q) back into the slot just read
               tos_q   <= bus.ram_rdata;
               wen_q   <= swap_q;
               state_q <= swap_q ? S_SW_WR : S_IDLE;
            end
            S_SW_WR:   state_q <= S_IDLE;
            default:   state_q <= S_IDLE;
         endcase
      end
   assign bus.cmd_ready = state_q == S_IDLE;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.tos       = tos_q;
   assign bus.count     = count_q;
   assign bus.err_ovf   = err_ovf_q;
   assign bus.err_unf   = err_unf_q;
   assign bus.ram_addr  = addr_q;
   assign bus.ram_wdata = wdata_q;
   assign bus.ram_wen   = wen_q;
endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: directed checks of stack_ctrl with an 8-bit and a 2-bit
// address instance, each backed by a behavioural scratch RAM.
module tb_stack_ctrl;
   import stack_pkg::*;
   logic CLK = 1'b0, resetn = 1'b0;
   always #5 CLK = ~CLK;
   stack_ctrl_if #(.DATA_W(32), .ADDR_W(8)) ia ();
   stack_ctrl_if #(.DATA_W(32), .ADDR_W(2)) ib ();
   stack_ctrl #(.DATA_W(32), .ADDR_W(8)) u_a (.CLK(CLK), .resetn(resetn), .bus(ia));
   stack_ctrl #(.DATA_W(32), .ADDR_W(2)) u_b (.CLK(CLK), .resetn(resetn), .bus(ib));
   logic        sel = 1'b0, valid = 1'b0, clr = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] data = '0;
   assign ia.cmd_valid = valid && !sel;
   assign ib.cmd_valid = valid && sel;
   assign ia.cmd_op    = op;
   assign ib.cmd_op    = op;
   assign ia.cmd_data  = data;
   assign ib.cmd_data  = data;
   assign ia.err_clr   = clr;
   assign ib.err_clr   = clr;
   logic [31:0] mema [256];
   logic [31:0] memb [4];
   int wen_a = 0, wen_b = 0, idle_wen = 0;
   always @(posedge CLK) begin
      if (ia.ram_wen) begin
         mema[ia.ram_addr] <= ia.ram_wdata;
         wen_a <= wen_a + 1;
      end
      ia.ram_rdata <= mema[ia.ram_addr];
      if (ib.ram_wen) begin
         memb[ib.ram_addr] <= ib.ram_wdata;
         wen_b <= wen_b + 1;
      end
      ib.ram_rdata <= memb[ib.ram_addr];
   end
   always @(negedge CLK)
      if ((ia.cmd_ready && ia.ram_wen) || (ib.cmd_ready && ib.ram_wen)) idle_wen <= idle_wen + 1;
   logic        rdy, rv, ovf, unf;
   logic [31:0] rd, tos;
   logic [8:0]  cnt;
   assign rdy = sel ? ib.cmd_ready : ia.cmd_ready;
   assign rv  = sel ? ib.rsp_valid : ia.rsp_valid;
   assign rd  = sel ? ib.rsp_data  : ia.rsp_data;
   assign tos = sel ? ib.tos       : ia.tos;
   assign cnt = sel ? {6'b0, ib.count} : ia.count;
   assign ovf = sel ? ib.err_ovf   : ia.err_ovf;
   assign unf = sel ? ib.err_unf   : ia.err_unf;
   int tests = 0, fails = 0;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic cmd(input logic [1:0] o, input logic [31:0] d);
      op = o;
      data = d;
      valid = 1'b1;
      @(posedge CLK);
      #1 valid = 1'b0;
   endtask
   task automatic gap(input string tag, input int exp);
      int n = 1;
      while (!rdy && n < 20) begin
         @(posedge CLK);
         #1 n++;
      end
      chk(tag, n, exp);
   endtask
   task automatic pop(input string tag, input logic [31:0] exp_rd, input int exp_gap);
      cmd(OP_POP, '0);
      chk({tag, "_rv"}, rv, 1);
      chk({tag, "_rd"}, rd, exp_rd);
      gap({tag, "_gap"}, exp_gap);
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int w0;
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_tos", tos, 0);
      chk("rst_cnt", cnt, 0);
      chk("rst_rdy", rdy, 1);
      chk("rst_rv", rv, 0);
      chk("rst_err", {ovf, unf}, 0);
      chk("rst_wen", ia.ram_wen, 0);
      @(negedge CLK) resetn = 1'b1;
      @(posedge CLK);
      #1 w0 = wen_a;
      cmd(OP_PUSH, 32'h11); gap("push1_gap", 1);
      cmd(OP_PUSH, 32'h22); gap("push2_gap", 2);
      cmd(OP_PUSH, 32'h33); gap("push3_gap", 2);
      chk("push_tos", tos, 32'h33);
      chk("push_cnt", cnt, 3);
      chk("ram0", mema[0], 32'h11);
      chk("ram1", mema[1], 32'h22);
      chk("push_wens", wen_a - w0, 2);
      cmd(OP_POP, '0);
      chk("pop1_rd", rd, 32'h33);
      chk("pop1_stale", tos, 32'h33);
      chk("pop1_cnt", cnt, 2);
      gap("pop1_gap", 3);
      chk("pop1_tos", tos, 32'h22);
      chk("pop1_rvlow", rv, 0);
      pop("pop2", 32'h22, 3);
      chk("pop2_tos", tos, 32'h11);
      pop("pop3", 32'h11, 1);
      chk("pop3_tos", tos, 0);
      chk("pop3_cnt", cnt, 0);
      cmd(OP_PUSH, 32'hA); gap("pa_gap", 1);
      cmd(OP_PUSH, 32'hB); gap("pb_gap", 2);
      cmd(OP_SWAP, '0);
      chk("swap_rv", rv, 1);
      chk("swap_rd", rd, 32'hB);
      gap("swap_gap", 4);
      chk("swap_tos", tos, 32'hA);
      chk("swap_cnt", cnt, 2);
      chk("swap_ram0", mema[0], 32'hB);
      pop("swpop", 32'hA, 3);
      chk("swpop_tos", tos, 32'hB);
      pop("last", 32'hB, 1);
      pop("unf", 32'h0, 1);
      chk("unf_flag", unf, 1);
      chk("unf_cnt", cnt, 0);
      clr = 1'b1;
      @(posedge CLK);
      #1 clr = 1'b0;
      chk("clr_unf", unf, 0);
      clr = 1'b1;
      cmd(OP_POP, '0);
      clr = 1'b0;
      chk("clrpri_rv", rv, 1);
      chk("clrpri_unf", unf, 0);
      cmd(OP_REPLACE, 32'h5); gap("rep_gap", 1);
      chk("rep_cnt", cnt, 1);
      chk("rep_tos", tos, 32'h5);
      cmd(OP_REPLACE, 32'h6);
      chk("rep2_cnt", cnt, 1);
      chk("rep2_tos", tos, 32'h6);
      cmd(OP_SWAP, '0);
      chk("swunf_rv", rv, 1);
      chk("swunf_rd", rd, 32'h6);
      chk("swunf_unf", unf, 1);
      chk("swunf_tos", tos, 32'h6);
      chk("swunf_cnt", cnt, 1);
      gap("swunf_gap", 1);
      clr = 1'b1;
      @(posedge CLK);
      #1 clr = 1'b0;
      cmd(OP_PUSH, 32'h66); gap("pre_rst_gap", 2);
      cmd(OP_POP, '0);
      chk("mid_busy", rdy, 0);
      resetn = 1'b0;
      #1;
      chk("mid_cnt", cnt, 0);
      chk("mid_tos", tos, 0);
      chk("mid_rdy", rdy, 1);
      chk("mid_wen", ia.ram_wen, 0);
      @(negedge CLK) resetn = 1'b1;
      @(posedge CLK);
      #1 chk("post_rdy", rdy, 1);
      sel = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         cmd(OP_PUSH, 32'(i));
         gap("fill_gap", i == 1 ? 1 : 2);
      end
      chk("fill_cnt", cnt, 5);
      chk("fill_tos", tos, 5);
      chk("fill_ram", {memb[0][7:0], memb[1][7:0], memb[2][7:0], memb[3][7:0]}, 32'h01020304);
      w0 = wen_b;
      cmd(OP_PUSH, 32'h6);
      chk("ovf_flag", ovf, 1);
      chk("ovf_cnt", cnt, 5);
      chk("ovf_tos", tos, 5);
      gap("ovf_gap", 1);
      chk("ovf_nowen", wen_b - w0, 0);
      for (int i = 5; i >= 1; i--) pop("drain", 32'(i), i > 1 ? 3 : 1);
      chk("drain_cnt", cnt, 0);
      chk("ovf_sticky", ovf, 1);
      chk("idle_wen", idle_wen, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
